// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: holds a word on the mux data input, walks sel
// across all eight positions, streams each returned bit and counts mux mismatches.
module mux8_scan_ctrl #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic [7:0] mux_data,
   output logic [2:0] mux_sel,
   input  logic       mux_out,
   output logic       bit_valid,
   output logic       bit_out,
   output logic       bit_last,
   input  logic       bit_ready,
   output logic       busy,
   output logic       err_pulse,
   output logic [3:0] err_cnt,
   output logic       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
   // ready/valid outputs depend only on registered state, never on the partner's signal.

   typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

   localparam logic [2:0] FIRST_SEL = LSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [2:0] LAST_SEL  = LSB_FIRST ? 3'd7 : 3'd0;

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_mux_data;
   logic [2:0] r_mux_sel;
   logic       r_err_pulse;
   logic [3:0] r_err_cnt;

   logic w_word_accept;
   logic w_beat_accept;
   logic w_is_last;
   logic w_mismatch;

   assign w_word_accept = (r_state == S_IDLE) && in_valid;
   assign w_beat_accept = (r_state == S_SCAN) && bit_ready;
   assign w_is_last     = (r_mux_sel == LAST_SEL);
   assign w_mismatch    = mux_out ^ r_mux_data[r_mux_sel];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_next_state = S_SCAN;
         S_SCAN: if (bit_ready && w_is_last) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Select and word hold after the last beat so the mux output stays quiet in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mux_data  <= 8'h00;
         r_mux_sel   <= 3'd0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= 4'd0;
      end else begin
         if (w_word_accept) begin
            r_mux_data <= in_data;
            r_mux_sel  <= FIRST_SEL;
         end else if (w_beat_accept && !w_is_last) begin
            r_mux_sel <= LSB_FIRST ? (r_mux_sel + 3'd1) : (r_mux_sel - 3'd1);
         end
         r_err_pulse <= w_beat_accept && w_mismatch;
         if (w_beat_accept && w_mismatch && (r_err_cnt != 4'hF)) begin
            r_err_cnt <= r_err_cnt + 4'd1;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign bit_valid = (r_state == S_SCAN);
   assign busy      = (r_state == S_SCAN);
   assign bit_last  = (r_state == S_SCAN) && w_is_last;
   assign bit_out   = mux_out;
   assign mux_data  = r_mux_data;
   assign mux_sel   = r_mux_sel;
   assign err_pulse = r_err_pulse;
   assign err_cnt   = r_err_cnt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: one LSB-first and one MSB-first instance, each driving
// a behavioural 8:1 mux with an optional stuck-inverting fault at sel 3.
module tb_mux8_scan_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic bit_ready = 1'b1;
   logic cur = 1'b1;
   logic fault_en = 1'b0;

   logic l_in_ready, l_bit_valid, l_bit_out, l_bit_last, l_busy, l_err_pulse, l_dbg, l_mux_out;
   logic [7:0] l_mux_data;
   logic [2:0] l_mux_sel;
   logic [3:0] l_err_cnt;
   logic m_in_ready, m_bit_valid, m_bit_out, m_bit_last, m_busy, m_err_pulse, m_dbg, m_mux_out;
   logic [7:0] m_mux_data;
   logic [2:0] m_mux_sel;
   logic [3:0] m_err_cnt;

   int checks = 0;
   int errors = 0;
   int cnt [2];

   always #5 clk = ~clk;

   // Behavioural mux, inverting its output at sel 3 while fault_en is set
   assign l_mux_out = l_mux_data[l_mux_sel] ^ (fault_en && (l_mux_sel == 3'd3));
   assign m_mux_out = m_mux_data[m_mux_sel] ^ (fault_en && (m_mux_sel == 3'd3));

   mux8_scan_ctrl #(.LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && cur), .in_ready(l_in_ready),
      .in_data(in_data), .mux_data(l_mux_data), .mux_sel(l_mux_sel), .mux_out(l_mux_out),
      .bit_valid(l_bit_valid), .bit_out(l_bit_out), .bit_last(l_bit_last),
      .bit_ready(bit_ready), .busy(l_busy), .err_pulse(l_err_pulse), .err_cnt(l_err_cnt),
      .dbg_state(l_dbg)
   );

   mux8_scan_ctrl #(.LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !cur), .in_ready(m_in_ready),
      .in_data(in_data), .mux_data(m_mux_data), .mux_sel(m_mux_sel), .mux_out(m_mux_out),
      .bit_valid(m_bit_valid), .bit_out(m_bit_out), .bit_last(m_bit_last),
      .bit_ready(bit_ready), .busy(m_busy), .err_pulse(m_err_pulse), .err_cnt(m_err_cnt),
      .dbg_state(m_dbg)
   );

   wire       o_in_ready  = cur ? l_in_ready  : m_in_ready;
   wire       o_bit_valid = cur ? l_bit_valid : m_bit_valid;
   wire       o_bit_out   = cur ? l_bit_out   : m_bit_out;
   wire       o_bit_last  = cur ? l_bit_last  : m_bit_last;
   wire       o_busy      = cur ? l_busy      : m_busy;
   wire       o_err_pulse = cur ? l_err_pulse : m_err_pulse;
   wire [7:0] o_mux_data  = cur ? l_mux_data  : m_mux_data;
   wire [2:0] o_mux_sel   = cur ? l_mux_sel   : m_mux_sel;
   wire [3:0] o_err_cnt   = cur ? l_err_cnt   : m_err_cnt;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_cnt(input int c);
      return (c > 15) ? 8'd15 : 8'(c);
   endfunction

   // Send one word and check every cycle of its scan. Stalls of slen cycles are
   // inserted before beats sa and sb; noise drives in_valid with 8'h00 while busy.
   task automatic run_word(input logic lsb, input logic [7:0] w, input int sa,
                           input int sb, input int slen, input logic noise,
                           input logic fault);
      int idx;
      int s;
      logic exp_bit;
      logic exp_err;
      logic pend;
      cur = lsb;
      fault_en = fault;
      bit_ready = 1'b1;
      chk("idle_in_ready", o_in_ready, 8'd1);
      chk("idle_bit_valid", o_bit_valid, 8'd0);
      chk("idle_busy", o_busy, 8'd0);
      in_valid = 1'b1;
      in_data = w;
      @(posedge clk);
      @(negedge clk);
      if (noise) begin
         in_valid = 1'b1;
         in_data = 8'h00;
      end else begin
         in_valid = 1'b0;
         in_data = 8'($urandom);
      end
      pend = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = lsb ? k : 7 - k;
         exp_err = fault && (idx == 3);
         exp_bit = w[idx] ^ exp_err;
         s = ((k == sa) || (k == sb)) ? slen : 0;
         for (int c = 0; c <= s; c++) begin
            chk("scan_bit_valid", o_bit_valid, 8'd1);
            chk("scan_in_ready", o_in_ready, 8'd0);
            chk("scan_busy", o_busy, 8'd1);
            chk("scan_mux_sel", o_mux_sel, 8'(idx));
            chk("scan_bit_out", o_bit_out, exp_bit);
            chk("scan_bit_last", o_bit_last, (k == 7));
            chk("scan_mux_data", o_mux_data, w);
            chk("scan_err_pulse", o_err_pulse, pend);
            chk("scan_err_cnt", o_err_cnt, exp_cnt(cnt[lsb]));
            bit_ready = (c == s);
            @(posedge clk);
            pend = (c == s) && exp_err;
            if (pend) cnt[lsb]++;
            @(negedge clk);
         end
      end
      bit_ready = 1'b1;
      chk("done_in_ready", o_in_ready, 8'd1);
      chk("done_bit_valid", o_bit_valid, 8'd0);
      chk("done_busy", o_busy, 8'd0);
      chk("done_bit_last", o_bit_last, 8'd0);
      chk("done_err_pulse", o_err_pulse, pend);
      chk("done_err_cnt", o_err_cnt, exp_cnt(cnt[lsb]));
      chk("done_mux_data", o_mux_data, w);
      chk("done_mux_sel", o_mux_sel, lsb ? 8'd7 : 8'd0);
   endtask

   initial begin
      cnt[0] = 0;
      cnt[1] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         cur = d[0];
         chk("rst_in_ready", o_in_ready, 8'd1);
         chk("rst_bit_valid", o_bit_valid, 8'd0);
         chk("rst_busy", o_busy, 8'd0);
         chk("rst_mux_data", o_mux_data, 8'h00);
         chk("rst_mux_sel", o_mux_sel, 8'd0);
         chk("rst_err_pulse", o_err_pulse, 8'd0);
         chk("rst_err_cnt", o_err_cnt, 8'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // basic LSB-first, MSB-first, backpressure
      run_word(1'b1, 8'b1010_1010, -1, -1, 0, 1'b0, 1'b0);
      run_word(1'b0, 8'hC3, -1, -1, 0, 1'b0, 1'b0);
      run_word(1'b1, 8'h5A, 2, 6, 3, 1'b0, 1'b0);
      run_word(1'b0, 8'h5A, 2, 6, 3, 1'b0, 1'b0);

      // busy-time input ignored, then captured once ready returns
      run_word(1'b1, 8'hFF, -1, -1, 0, 1'b1, 1'b0);
      run_word(1'b1, 8'h00, -1, -1, 0, 1'b0, 1'b0);

      // fault injection and counter saturation
      run_word(1'b1, 8'hFF, -1, -1, 0, 1'b0, 1'b1);
      run_word(1'b1, 8'hFF, -1, -1, 0, 1'b0, 1'b1);
      chk("fault_cnt_two", o_err_cnt, 8'd2);
      for (int n = 0; n < 20; n++) run_word(1'b1, 8'($urandom), -1, -1, 0, 1'b0, 1'b1);
      chk("fault_cnt_sat", o_err_cnt, 8'd15);
      run_word(1'b0, 8'h3C, 1, -1, 2, 1'b0, 1'b1);

      // reset at beat 4 abandons the word and clears the counter
      cur = 1'b1;
      fault_en = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h96;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      bit_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_mux_sel", o_mux_sel, 8'd4);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cnt[0] = 0;
      cnt[1] = 0;
      chk("midrst_bit_valid", o_bit_valid, 8'd0);
      chk("midrst_bit_last", o_bit_last, 8'd0);
      chk("midrst_mux_sel", o_mux_sel, 8'd0);
      chk("midrst_mux_data", o_mux_data, 8'h00);
      chk("midrst_err_cnt", o_err_cnt, 8'd0);
      chk("midrst_in_ready", o_in_ready, 8'd1);
      @(negedge clk);
      chk("midrst_still_idle", o_bit_valid, 8'd0);
      run_word(1'b1, 8'($urandom), -1, -1, 0, 1'b0, 1'b0);

      // randomized words, directions, stalls and faults
      for (int n = 0; n < 24; n++) begin
         run_word(1'($urandom_range(0, 1)), 8'($urandom),
                  $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
